// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared types and constants for the host-side serial command link
package remote_comm_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

  // Response codes shared with the robot-side command receiver
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'h5A;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/remote_comm_if.sv
// rtl/remote_comm_if.sv - host-side command/response handshake bundle
interface remote_comm_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        busy;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        ack;
  logic        timeout;

  modport master (output cmd, send_cmd, input busy, cmd_sent, resp, resp_rdy, ack, timeout);
  modport slave  (input cmd, send_cmd, output busy, cmd_sent, resp, resp_rdy, ack, timeout);
endinterface

// File: rtl/UART_rcv.sv
// rtl/UART_rcv.sv - 8N1 receiver sampling mid-bit; rdy holds until clr_rdy
module UART_rcv #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);
  localparam int BW = $clog2(BAUD_CYCLES);

  logic          rx1_q, rx1_d, rx2_q, rx2_d;
  logic          rcv_q, rcv_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shft_q, shft_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    rx1_d  = RX;
    rx2_d  = rx1_q;
    rcv_d  = rcv_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    shft_d = shft_q;
    rdy_d  = rdy_q & ~clr_rdy;
    if (!rcv_q) begin
      if (!rx2_q) begin
        rcv_d  = 1'b1;
        baud_d = BW'(BAUD_CYCLES / 2);
        bit_d  = '0;
      end
    end else if (baud_q == '0) begin
      baud_d = BW'(BAUD_CYCLES - 1);
      bit_d  = bit_q + 4'd1;
      if (bit_q != 4'd0 && bit_q != 4'd9) shft_d = {rx2_q, shft_q[7:1]};
      if (bit_q == 4'd9) begin
        rcv_d = 1'b0;
        rdy_d = 1'b1;
      end
    end else begin
      baud_d = baud_q - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx1_q  <= 1'b1;
      rx2_q  <= 1'b1;
      rcv_q  <= 1'b0;
      baud_q <= '0;
      bit_q  <= '0;
      shft_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rx1_q  <= rx1_d;
      rx2_q  <= rx2_d;
      rcv_q  <= rcv_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      shft_q <= shft_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rx_data = shft_q;
  assign rdy     = rdy_q;

endmodule

// File: rtl/UART_tx.sv
// rtl/UART_tx.sv - 8N1 transmitter; tx_done is sticky until the next trmt
module UART_tx #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_CYCLES);

  logic [8:0]    shft_q, shft_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    shft_d = shft_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    busy_d = busy_q;
    done_d = done_q;
    if (trmt) begin
      shft_d = {tx_data, 1'b0};
      baud_d = '0;
      bit_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      if (baud_q == BW'(BAUD_CYCLES - 1)) begin
        // Ones shift in behind the data, so the stop bit and idle level come for free
        baud_d = '0;
        shft_d = {1'b1, shft_q[8:1]};
        bit_d  = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft_q <= '1;
      baud_q <= '0;
      bit_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      shft_q <= shft_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign TX      = shft_q[0];
  assign tx_done = done_q;

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host command initiator: sends a 16-bit command as two bytes, awaits one reply
module remote_comm #(
  parameter int         RESP_TIMEOUT = 1000000,
  parameter logic [7:0] ACK_BYTE     = remote_comm_pkg::ACK_BYTE,
  parameter int         BAUD_CYCLES  = 2604
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  remote_comm_if.slave  host
);
  import remote_comm_pkg::*;

  localparam int            CW   = cnt_width(RESP_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(RESP_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   cmd_buf_q, cmd_buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    resp_q, resp_d;
  logic          busy_q, busy_d;
  logic          cmd_sent_q, cmd_sent_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic          timeout_q, timeout_d;
  logic          trmt_seen_q;

  logic       trmt, tx_done, tx_ok, rdy, clr_rdy;
  logic [7:0] tx_data, rx_data;

  // tx_done is stale in the cycle after trmt, so it is masked there
  assign tx_ok   = tx_done & ~trmt_seen_q;
  assign clr_rdy = rdy;

  UART_tx #(.BAUD_CYCLES(BAUD_CYCLES)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .TX(TX), .tx_done(tx_done)
  );

  UART_rcv #(.BAUD_CYCLES(BAUD_CYCLES)) u_rcv (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy), .rx_data(rx_data), .rdy(rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_buf_q   <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      busy_q      <= 1'b0;
      cmd_sent_q  <= 1'b0;
      resp_rdy_q  <= 1'b0;
      timeout_q   <= 1'b0;
      trmt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_buf_q   <= cmd_buf_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
      cmd_sent_q  <= cmd_sent_d;
      resp_rdy_q  <= resp_rdy_d;
      timeout_q   <= timeout_d;
      trmt_seen_q <= trmt;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (host.send_cmd) state_d = TX_HI;
      TX_HI:     if (tx_ok) state_d = TX_LO;
      TX_LO:     if (tx_ok) state_d = WAIT_RESP;
      WAIT_RESP: if (rdy || cnt_q == LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_buf_d  = cmd_buf_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    busy_d     = busy_q;
    cmd_sent_d = 1'b0;
    resp_rdy_d = resp_rdy_q;
    timeout_d  = timeout_q;
    trmt       = 1'b0;
    // A reply is captured in any state, even one that arrives before WAIT_RESP
    if (rdy) begin
      resp_d     = rx_data;
      resp_rdy_d = 1'b1;
    end
    case (state_q)
      IDLE: if (host.send_cmd) begin
        cmd_buf_d  = host.cmd;
        trmt       = 1'b1;
        resp_rdy_d = 1'b0;
        timeout_d  = 1'b0;
        busy_d     = 1'b1;
      end
      TX_HI: if (tx_ok) begin
        cmd_buf_d = {cmd_buf_q[7:0], 8'h00};
        trmt      = 1'b1;
      end
      TX_LO: if (tx_ok) begin
        cmd_sent_d = 1'b1;
        cnt_d      = '0;
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (rdy) begin
          busy_d = 1'b0;
        end else if (cnt_q == LAST) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
    tx_data = cmd_buf_d[15:8];
  end

  assign host.busy     = busy_q;
  assign host.cmd_sent = cmd_sent_q;
  assign host.resp     = resp_q;
  assign host.resp_rdy = resp_rdy_q;
  assign host.ack      = resp_rdy_q && (resp_q == ACK_BYTE);
  assign host.timeout  = timeout_q;

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - directed self-checking bench for remote_comm
module tb_remote_comm;
  localparam int BAUD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   checks = 0;
  int   failures = 0;
  int   sent_cnt = 0;
  int   clr_cnt = 0;

  remote_comm_if bus ();

  remote_comm #(.RESP_TIMEOUT(100), .ACK_BYTE(8'hA5), .BAUD_CYCLES(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .host(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cmd_sent === 1'b1) sent_cnt++;
    if (dut.clr_rdy === 1'b1) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] c);
    @(negedge clk);
    bus.cmd = c;
    bus.send_cmd = 1'b1;
    @(negedge clk);
    bus.send_cmd = 1'b0;
  endtask

  task automatic rx_byte(output logic found, output int lat, output logic [7:0] data,
                         output logic st, output logic sp);
    lat = 0;
    while (tx !== 1'b0 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    found = (tx === 1'b0);
    repeat (BAUD / 2) @(negedge clk);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      data[i] = tx;
    end
    repeat (BAUD) @(negedge clk);
    sp = tx;
  endtask

  task automatic wait_sent(output logic found, output int n);
    n = 0;
    while (bus.cmd_sent !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    found = (bus.cmd_sent === 1'b1);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic get_frame(input string tag, input logic [7:0] exp_byte, output int lat);
    logic       f, st, sp;
    logic [7:0] d;
    rx_byte(f, lat, d, st, sp);
    check({tag, "_found"}, 32'(f), 32'd1);
    check({tag, "_start"}, 32'(st), 32'd0);
    check({tag, "_data"}, 32'(d), 32'(exp_byte));
    check({tag, "_stop"}, 32'(sp), 32'd1);
  endtask

  initial begin
    logic found, txlow;
    int   lat, n, k, s0, c0;

    bus.cmd = 16'h0000;
    bus.send_cmd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
    check("rst_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_resp", 32'(bus.resp), 32'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic send followed by an ACK reply
    s0 = sent_cnt;
    send(16'h2A5C);
    check("basic_busy", 32'(bus.busy), 32'd1);
    get_frame("basic_hi", 8'h2A, lat);
    check("basic_start_latency", 32'(lat <= 2), 32'd1);
    get_frame("basic_lo", 8'h5C, lat);
    check("basic_frame_gap", 32'(lat <= BAUD / 2 + 1), 32'd1);
    wait_sent(found, n);
    check("basic_sent_found", 32'(found), 32'd1);
    check("basic_sent_at_stop_end", 32'(n >= BAUD / 2 && n <= BAUD / 2 + 2), 32'd1);
    check("basic_busy_at_sent", 32'(bus.busy), 32'd1);
    c0 = clr_cnt;
    drive_rx(8'hA5);
    repeat (2) @(negedge clk);
    check("basic_sent_once", 32'(sent_cnt - s0), 32'd1);
    check("ack_resp", 32'(bus.resp), 32'hA5);
    check("ack_resp_rdy", 32'(bus.resp_rdy), 32'd1);
    check("ack_ack", 32'(bus.ack), 32'd1);
    check("ack_busy", 32'(bus.busy), 32'd0);
    check("ack_timeout", 32'(bus.timeout), 32'd0);
    check("ack_clr_rdy_pulses", 32'(clr_cnt - c0), 32'd1);

    // NAK reply
    send(16'h8001);
    check("nak_rdy_cleared", 32'(bus.resp_rdy), 32'd0);
    get_frame("nak_hi", 8'h80, lat);
    get_frame("nak_lo", 8'h01, lat);
    wait_sent(found, n);
    check("nak_sent_found", 32'(found), 32'd1);
    drive_rx(8'h5A);
    repeat (2) @(negedge clk);
    check("nak_resp", 32'(bus.resp), 32'h5A);
    check("nak_resp_rdy", 32'(bus.resp_rdy), 32'd1);
    check("nak_ack", 32'(bus.ack), 32'd0);

    // Busy rejection, then no reply so the response timer expires
    s0 = sent_cnt;
    send(16'h1234);
    bus.cmd = 16'hFFFF;
    bus.send_cmd = 1'b1;
    @(negedge clk);
    bus.send_cmd = 1'b0;
    get_frame("rej_hi", 8'h12, lat);
    get_frame("rej_lo", 8'h34, lat);
    wait_sent(found, n);
    check("rej_sent_found", 32'(found), 32'd1);
    k = 0;
    txlow = 1'b0;
    while (bus.timeout !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      if (tx === 1'b0) txlow = 1'b1;
    end
    check("to_cycles_after_sent", 32'(k), 32'd100);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    check("rej_no_extra_byte", 32'(txlow), 32'd0);
    check("rej_sent_once", 32'(sent_cnt - s0), 32'd1);

    // Next send clears timeout; reset lands inside the high byte's data bits
    send(16'h0011);
    check("to_cleared_by_send", 32'(bus.timeout), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    repeat (10) @(negedge clk);
    check("mid_tx_low_data", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
    check("mid_rst_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    check("mid_rst_ack", 32'(bus.ack), 32'd0);
    check("mid_rst_timeout", 32'(bus.timeout), 32'd0);
    check("mid_rst_resp", 32'(bus.resp), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(16'h00FF);
    get_frame("post_hi", 8'h00, lat);
    get_frame("post_lo", 8'hFF, lat);
    wait_sent(found, n);
    check("post_sent_found", 32'(found), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Host-side command initiator for the MazeRunner serial link. It serializes a 16-bit command into two UART bytes, high byte first, then waits for the single response byte from the robot.
- It sits at the opposite end of the link from the robot's command receiver and drives the physical TX/RX pair directly.
- It is used by the full-chip testbench and by the remote-control top level.

Parameters:
- RESP_TIMEOUT, 1000000, clock cycles allowed in WAIT_RESP for the response byte before timeout is flagged; must be at least 1.
- ACK_BYTE, 8'hA5, response value treated as positive acknowledge.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial in from robot TX; idles high
- TX  output  1  serial out to robot RX; idles high
- cmd  input  16  command word; sampled only on an accepted send_cmd
- send_cmd  input  1  single-cycle request to send cmd
- busy  output  1  high from send_cmd acceptance until return to IDLE
- cmd_sent  output  1  one-cycle pulse when the low byte's stop bit completes
- resp  output  8  last response byte received
- resp_rdy  output  1  high when resp holds a new byte; cleared by the next accepted send_cmd
- ack  output  1  resp_rdy && (resp == ACK_BYTE)
- timeout  output  1  sticky; set on response timeout, cleared by the next accepted send_cmd

Behaviour:
- Reset: asynchronous, active-low; one clock; no other reset.
  - On reset, state = IDLE, and TX = 1 (the transmitter's idle level).
  - busy, cmd_sent, resp_rdy, ack and timeout are all 0; resp = 8'h00.
  - The internal command buffer and timeout counter are cleared.
- Byte transport: uses the codebase UART_tx and UART_rcv at the codebase baud rate, with 10-bit frames of 1 start, 8 data (LSB first) and 1 stop bit.
  - UART_tx tx_done is sticky. trmt clears it the next cycle, and it is set at stop-bit end.
  - The FSM must not sample tx_done in the cycle trmt is asserted, or in the cycle after.
- FSM states: IDLE, TX_HI, TX_LO, WAIT_RESP.
- IDLE:
  - On send_cmd, latch cmd into cmd_buf and pulse trmt with tx_data = cmd_buf[15:8].
  - In the same cycle: clear resp_rdy and timeout, set busy, go to TX_HI.
- TX_HI: on tx_done, pulse trmt with tx_data = cmd_buf[7:0] and go to TX_LO. There is no idle gap between frames beyond one clock.
- TX_LO: on tx_done, pulse cmd_sent for one cycle, zero the timeout counter and go to WAIT_RESP.
- WAIT_RESP:
  - Counter increments each cycle.
  - On UART_rcv rdy: latch rx_data into resp, set resp_rdy, pulse clr_rdy for one cycle, clear busy, go to IDLE.
  - If counter reaches RESP_TIMEOUT-1 without rdy: set timeout, clear busy, go to IDLE; resp is unchanged.
  - rdy and the terminal count in the same cycle: the response wins and timeout stays 0.
- send_cmd while busy: ignored; cmd_buf must not change and no extra byte is sent.
- send_cmd in the same cycle that the FSM returns to IDLE: ignored; it is accepted from the following cycle.
- Response arriving in IDLE, TX_HI or TX_LO (unsolicited or early):
  - Still latched into resp, with resp_rdy set and clr_rdy pulsed.
  - The FSM is not disturbed. If it arrives before WAIT_RESP, WAIT_RESP still waits for a further byte.
- A second byte before resp_rdy is cleared overwrites resp; there is no overrun flag.
- Reset mid-frame: TX returns high immediately. A partial frame on the wire is abandoned, and the far end must treat it as a framing error.
- Latency from an accepted send_cmd:
  - First start bit appears on TX within 2 cycles.
  - cmd_sent comes about 20 bit-times later.

Decomposition:
- Package remote_comm_pkg holds:
  - the state enum (IDLE, TX_HI, TX_LO, WAIT_RESP);
  - ACK_BYTE and NAK_BYTE (8'hA5 / 8'h5A) shared with the robot-side command receiver;
  - the command opcode field positions, cmd[15:12].
- Sub-modules: UART_tx and UART_rcv are instantiated directly. They are not instantiated through the combined transceiver wrapper, whose receive input is internally looped to its own TX.
- No further sub-module is needed.
- The timeout counter width is $clog2(RESP_TIMEOUT).

Test Plan:
- Basic send: cmd=16'h2A5C, send_cmd pulse.
  - TX carries 8'h2A then 8'h5C, LSB first, with correct start/stop bits.
  - cmd_sent pulses once at the end of the 8'h5C stop bit; busy stays high.
- Ack path: after cmd_sent, a behavioural UART model drives 8'hA5 on RX.
  - resp=8'hA5, resp_rdy=1, ack=1, busy=0; one clr_rdy pulse is seen internally.
- NAK path: same as the ack path, but RX carries 8'h5A.
  - resp=8'h5A, resp_rdy=1, ack=0.
- Timeout: RESP_TIMEOUT=100, no RX activity after cmd_sent.
  - Exactly 100 cycles after cmd_sent, timeout=1, busy=0, resp_rdy=0.
  - A following send_cmd clears timeout.
- Busy rejection: send 16'h1234, then send_cmd with cmd=16'hFFFF during TX_HI.
  - Only bytes 8'h12 and 8'h34 appear on TX; exactly one cmd_sent pulse.
- Reset mid-operation: assert rst_n=0 during the data bits of the high byte.
  - TX=1 and all outputs are at reset values within the reset cycle.
  - After release, a new send of 16'h00FF transmits correctly.
